// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered, handshaked rv32im_zbb control decode with RUN/DRAIN/HALTED intake control.
// Define DECODE_PERF_CNT_EN to add the decoded/illegal/stall performance counters.
module ctrl_decode_stage #(
    parameter int WE_WIDTH        = 4,
    parameter int M_SUPPORT       = 1,
    parameter int ZBB_SUPPORT     = 1,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         instr_i,
    input  logic [31:0]         pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                mem_to_reg_o,
    output logic                rd_we_o,
    output logic                alu_src_b_o,
    output logic                branch_o,
    output logic                rs1_in_use_o,
    output logic                rs2_in_use_o,
    output logic                pc_operand_o,
    output logic                stop_flag_o,
    output logic                illegal_o,
    output logic [WE_WIDTH-1:0] data_mem_we_o,
    output logic [1:0]          alu_2bit_op_o,
    output logic [4:0]          rd_addr_o,
    output logic [4:0]          rs1_addr_o,
    output logic [4:0]          rs2_addr_o,
    output logic [2:0]          funct3_o,
    output logic [31:0]         pc_o,
    input  logic                flush_i,
    input  logic                resume_i,
    output logic                halted_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]         perf_decoded_o,
    output logic [31:0]         perf_illegal_o,
    output logic [31:0]         perf_stall_o
`endif
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic       W8        = (WE_WIDTH == 8);
    localparam logic       M_EN      = (M_SUPPORT != 0);
    localparam logic       ZBB       = (ZBB_SUPPORT != 0);
    localparam logic       HALT_ILL  = (HALT_ON_ILLEGAL != 0);

    typedef struct packed {
        logic                mem_to_reg;
        logic                rd_we;
        logic                alu_src_b;
        logic                branch;
        logic                rs1_use;
        logic                rs2_use;
        logic                pc_op;
        logic                stop;
        logic                illegal;
        logic [WE_WIDTH-1:0] we;
        logic [1:0]          alu_op;
    } ctl_t;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic        w_legal, w_r_legal, w_load, w_consume;
    ctl_t        w_dec, w_ctl, r_ctl;
    state_t      r_state, w_state_nxt;
    logic        r_valid;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [2:0]  r_f3;
    logic [31:0] r_pc;

    assign w_op = instr_i[6:0];
    assign w_f3 = instr_i[14:12];
    assign w_f7 = instr_i[31:25];

    always_comb begin
        w_r_legal = (w_f7 == 7'b0000000)
                 || (w_f7 == 7'b0100000 && (w_f3 inside {3'b000, 3'b101}
                     || (ZBB && w_f3 inside {3'b100, 3'b110, 3'b111})))
                 || (w_f7 == 7'b0000001 && M_EN)
                 || (w_f7 == 7'b0000101 && ZBB)
                 || (w_f7 == 7'b0110000 && ZBB && w_f3 inside {3'b001, 3'b101})
                 || (w_f7 == 7'b0000100 && ZBB && w_f3 == 3'b100 && instr_i[24:20] == 5'd0);
        w_dec   = '0;
        w_legal = 1'b1;
        case (w_op)
            OP_R: begin
                w_dec.alu_op  = 2'b10;
                w_dec.rd_we   = 1'b1;
                w_dec.rs1_use = 1'b1;
                w_dec.rs2_use = 1'b1;
                w_legal       = w_r_legal;
            end
            OP_IMM: begin
                w_dec.alu_op    = 2'b11;
                w_dec.alu_src_b = 1'b1;
            end
            OP_LOAD: begin
                w_dec.mem_to_reg = 1'b1;
                w_dec.rd_we      = 1'b1;
                w_dec.alu_src_b  = 1'b1;
                w_legal = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}
                       || (W8 && w_f3 inside {3'b011, 3'b110});
            end
            OP_BRANCH: begin
                w_dec.alu_op    = 2'b01;
                w_dec.branch    = 1'b1;
                w_dec.rs1_use   = 1'b1;
                w_dec.rs2_use   = 1'b1;
                w_dec.alu_src_b = 1'b1;
                w_legal         = !(w_f3 inside {3'b010, 3'b011});
            end
            OP_STORE: begin
                w_dec.rs1_use   = 1'b1;
                w_dec.rs2_use   = 1'b1;
                w_dec.alu_src_b = 1'b1;
                w_dec.we = w_f3 == 3'b000 ? WE_WIDTH'(1) :
                           w_f3 == 3'b001 ? WE_WIDTH'(3) :
                           w_f3 == 3'b010 ? WE_WIDTH'(15) : '1;
                w_legal = w_f3 inside {3'b000, 3'b001, 3'b010} || (W8 && w_f3 == 3'b011);
            end
            OP_JALR: begin
                w_dec.branch  = 1'b1;
                w_dec.rd_we   = 1'b1;
                w_dec.rs1_use = 1'b1;
                w_dec.pc_op   = 1'b1;
                w_legal       = w_f3 == 3'b000;
            end
            OP_JAL: begin
                w_dec.branch = 1'b1;
                w_dec.rd_we  = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.rd_we = 1'b1;
                w_dec.pc_op = 1'b1;
            end
            OP_LUI:    w_dec.rd_we = 1'b1;
            OP_SYSTEM: w_dec.stop  = 1'b1;
            default:   w_legal     = 1'b0;
        endcase
        w_ctl = w_dec;
        if (!w_legal) begin
            w_ctl         = '0;
            w_ctl.illegal = 1'b1;
            w_ctl.stop    = HALT_ILL;
        end
    end

    // Flush blocks intake combinationally so a redirect never races a new load.
    assign in_ready_o = rst_ni && r_state == S_RUN && !flush_i && (!r_valid || out_ready_i);
    assign w_load     = in_valid_i && in_ready_o;
    assign w_consume  = r_valid && out_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    w_state_nxt = (w_load && w_ctl.stop) ? S_DRAIN : S_RUN;
            S_DRAIN:  w_state_nxt = flush_i ? S_RUN : (w_consume ? S_HALTED : S_DRAIN);
            S_HALTED: w_state_nxt = resume_i ? S_RUN : S_HALTED;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_RUN;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_ctl   <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_f3    <= '0;
            r_pc    <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_ctl   <= w_ctl;
            r_rd    <= instr_i[11:7];
            r_rs1   <= instr_i[19:15];
            r_rs2   <= instr_i[24:20];
            r_f3    <= w_f3;
            r_pc    <= pc_i;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid_o   = r_valid;
    assign mem_to_reg_o  = r_ctl.mem_to_reg;
    assign rd_we_o       = r_ctl.rd_we;
    assign alu_src_b_o   = r_ctl.alu_src_b;
    assign branch_o      = r_ctl.branch;
    assign rs1_in_use_o  = r_ctl.rs1_use;
    assign rs2_in_use_o  = r_ctl.rs2_use;
    assign pc_operand_o  = r_ctl.pc_op;
    assign stop_flag_o   = r_ctl.stop;
    assign illegal_o     = r_ctl.illegal;
    assign data_mem_we_o = r_ctl.we;
    assign alu_2bit_op_o = r_ctl.alu_op;
    assign rd_addr_o     = r_rd;
    assign rs1_addr_o    = r_rs1;
    assign rs2_addr_o    = r_rs2;
    assign funct3_o      = r_f3;
    assign pc_o          = r_pc;
    assign halted_o      = r_state == S_HALTED;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_perf_dec, r_perf_ill, r_perf_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_dec   <= '0;
            r_perf_ill   <= '0;
            r_perf_stall <= '0;
        end else begin
            r_perf_dec   <= r_perf_dec + 32'(w_load);
            r_perf_ill   <= r_perf_ill + 32'(w_load && w_ctl.illegal);
            r_perf_stall <= r_perf_stall + 32'(in_valid_i && !in_ready_o);
        end
    end

    assign perf_decoded_o = r_perf_dec;
    assign perf_illegal_o = r_perf_ill;
    assign perf_stall_o   = r_perf_stall;
`endif
endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
Registered, handshaked control decode stage for the rv32im_zbb pipeline. It sits between fetch and execute. The block decodes opcode, funct3 and funct7 into the standard control bundle, detects illegal encodings for the configured extensions, and carries a run/drain/halt state machine that stops instruction intake after ECALL/EBREAK or an illegal instruction.

Parameters:
WE_WIDTH, 4, byte-lane width of data_mem_we_o; legal values 4 or 8 (8 enables SD, funct3 011).
M_SUPPORT, 1, 1 = funct7 0000001 R-type (MUL/DIV) is legal.
ZBB_SUPPORT, 1, 1 = Zbb R-type encodings are legal.
HALT_ON_ILLEGAL, 1, 1 = an illegal instruction halts like ECALL; 0 = it passes with illegal_o=1 and no halt.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  instr_i/pc_i valid
in_ready_o  out  1  stage accepts input this cycle
instr_i  in  32  instruction word
pc_i  in  32  instruction PC
out_valid_o  out  1  output bundle valid
out_ready_i  in  1  execute accepts bundle
mem_to_reg_o, rd_we_o, alu_src_b_o, branch_o, rs1_in_use_o, rs2_in_use_o, pc_operand_o, stop_flag_o, illegal_o  out  1 each  registered control bits
data_mem_we_o  out  WE_WIDTH  store byte enables
alu_2bit_op_o  out  2  ALU class
rd_addr_o, rs1_addr_o, rs2_addr_o  out  5 each  register fields
funct3_o  out  3  funct3 passthrough
pc_o  out  32  PC passthrough
flush_i  in  1  kill the held bundle (branch redirect)
resume_i  in  1  leave HALTED
halted_o  out  1  core halted

Behaviour:
- Reset (async, rst_ni=0): all outputs 0; state RUN; in_ready_o=1 once released.
- Control encoding per opcode:
  - R: alu_op 10, rd_we, rs1, rs2.
  - I-ALU: 11, imm.
  - LOAD: 00, mem_to_reg, rd_we, imm.
  - BRANCH: 01, branch, rs1, rs2, imm.
  - STORE: 00, rs1, rs2, imm, byte enables.
  - JALR: branch, rd_we, rs1, pc_operand.
  - JAL: branch, rd_we.
  - AUIPC: rd_we, pc_operand.
  - LUI: rd_we.
  - SYSTEM: stop_flag. All other controls 0.
- Store enables: SB 0…01; SH 0…011; SW 0…01111; SD all-ones (WE_WIDTH=8 only). Any other funct3 is illegal.
- Legal funct3 rules:
  - LOAD: {000,001,010,100,101}, plus 011/110 when WE_WIDTH=8.
  - BRANCH: funct3 not 010/011.
  - JALR: funct3 = 000.
- R-type legal funct7:
  - 0000000 always.
  - 0100000 with f3 000/101 always; with f3 100/110/111 if ZBB_SUPPORT.
  - 0000001 if M_SUPPORT.
  - 0000101 and 0110000 (f3 001/101) if ZBB_SUPPORT.
  - 0000100 with f3 100 and rs2=0 (zext.h) if ZBB_SUPPORT.
- Illegal or unknown opcode: all write/branch controls are forced 0, illegal_o=1; stop_flag_o=1 iff HALT_ON_ILLEGAL.
- Pipeline register, latency 1:
  - in_ready_o = (state==RUN) && (!out_valid_o || out_ready_i).
  - Transfer on in_valid_i && in_ready_o loads the bundle; out_valid_o=1 the next cycle.
  - Output handshake without a new load: out_valid_o clears.
  - Simultaneous output consume and new input: back-to-back, no bubble.
  - Bundle fields hold stable while out_valid_o && !out_ready_i.
- FSM: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when an accepted instruction has stop_flag set; intake stops immediately.
  - DRAIN -> HALTED when the halting bundle completes its output handshake; halted_o=1 from the next cycle.
  - HALTED -> RUN on resume_i; halted_o clears the next cycle.
- Flush (flush_i=1):
  - Clears out_valid_o the next cycle and blocks intake that cycle (in_ready_o=0).
  - In DRAIN, flush cancels the halt and returns to RUN.
  - Ignored in HALTED.
- Priority: reset > flush > output/input transfer > resume. resume_i outside HALTED is ignored.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined, three 32-bit output ports are added: perf_decoded_o (input transfers), perf_illegal_o (accepted illegal instructions), perf_stall_o (cycles with in_valid_i && !in_ready_o).
- Counters wrap at 2^32, reset to 0, and do not count flushed-away bundles twice.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- ADD (0x003100B3) in, out_ready_i=1: one cycle later out_valid_o=1, alu_op=10, rd_we=1, rs1/rs2 in use, rd_addr=1, illegal_o=0.
- SH then SW back-to-back with out_ready_i held 1: data_mem_we_o 0011 then 1111 on consecutive cycles, in_ready_o stays 1.
- out_ready_i=0 for 3 cycles with LW held: outputs stable, in_ready_o=0, stall count=3 (macro on).
- ECALL (0x00000073): in_ready_o=0 from the next cycle. Bundle consumed -> halted_o=1. resume_i pulse -> RUN, in_ready_o=1.
- MUL (funct7 0000001) with M_SUPPORT=0: illegal_o=1, rd_we=0, halt sequence occurs. Same with HALT_ON_ILLEGAL=0: no halt, stop_flag_o=0.
- ECALL accepted then flush_i in DRAIN: out_valid_o=0, state RUN, halted_o stays 0. Assert rst_ni low mid-stall -> all outputs 0 immediately.
